// File: rtl/bit_serial_adder_pkg.sv
// rtl/bit_serial_adder_pkg.sv - shared types and constants for the bit-serial adder
package bit_serial_adder_pkg;

   // Default operand/result width
   localparam int DEFAULT_WIDTH = 8;

   // Controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bit-counter width; one extra bit so the count can never wrap inside a transaction
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// rtl/serial_fa_cell.sv - combinational full-adder bit built from two half adders
module serial_fa_cell (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);

   logic w_p1;
   logic w_g1;
   logic w_g2;

   // First half adder: operand bits; second: partial sum with carry-in
   assign w_p1 = i_a ^ i_b;
   assign w_g1 = i_a & i_b;
   assign o_s  = w_p1 ^ i_c;
   assign w_g2 = w_p1 & i_c;
   assign o_c  = w_g1 | w_g2;

endmodule

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - LSB-first bit-serial adder with valid/ready handshakes
module bit_serial_adder
   import bit_serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             bit_a,
   output logic             bit_b,
   output logic             bit_s,
   output logic             bit_c,
   output logic             busy
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;

   logic w_hs_in;
   logic w_last;
   logic w_s;
   logic w_c;

   assign in_ready  = (r_state == IDLE);
   assign w_hs_in   = in_valid & in_ready;
   assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state == SHIFT) || (r_state == DONE);
   assign sum       = r_sum;
   assign cout      = r_carry;

   serial_fa_cell u_fa (
      .i_a (r_a[0]),
      .i_b (r_b[0]),
      .i_c (r_carry),
      .o_s (w_s),
      .o_c (w_c)
   );

   // Debug pins show live serial bits only while shifting; carry is always visible
   assign bit_a = (r_state == SHIFT) ? r_a[0] : 1'b0;
   assign bit_b = (r_state == SHIFT) ? r_b[0] : 1'b0;
   assign bit_s = (r_state == SHIFT) ? w_s    : 1'b0;
   assign bit_c = r_carry;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_hs_in)   w_next = SHIFT;
         SHIFT:   if (w_last)    w_next = DONE;
         DONE:    if (out_ready) w_next = IDLE;
         default:                w_next = IDLE;
      endcase
   end

   // Datapath: load on accept, one bit per cycle while shifting, hold otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (w_hs_in) begin
         r_a     <= a;
         r_b     <= b;
         r_carry <= cin;
         r_cnt   <= '0;
      end else if (r_state == SHIFT) begin
         r_sum   <= {w_s, r_sum[WIDTH-1:1]};
         r_a     <= {1'b0, r_a[WIDTH-1:1]};
         r_b     <= {1'b0, r_b[WIDTH-1:1]};
         r_carry <= w_c;
         r_cnt   <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/bit_serial_adder.md
BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits; legal range is 2..16.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 in_valid  input  1  SHALL mean the operands a, b and cin are valid.
REQ-005 in_ready  output  1  SHALL mean the block accepts operands this cycle.
REQ-006 a, b  input  WIDTH each  SHALL carry the operands, unsigned.
REQ-007 cin  input  1  SHALL carry the carry-in of the addition.
REQ-008 sum  output  WIDTH  SHALL carry the result, valid while out_valid is high.
REQ-009 cout  output  1  SHALL carry the carry-out, valid while out_valid is high.
REQ-010 out_valid  output  1  SHALL mean sum and cout are valid.
REQ-011 out_ready  input  1  SHALL mean the consumer takes the result this cycle.
REQ-012 bit_a, bit_b, bit_s, bit_c  output  1 each  SHALL expose the current serial operand bits, sum bit and carry register for debug pins.
REQ-013 busy  output  1  SHALL be high in SHIFT and DONE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE, and the input handshake SHALL be in_valid & in_ready.
REQ-016 On an input handshake:
- a and b SHALL load into shift registers;
- cin SHALL load the carry register;
- the bit counter SHALL clear;
- the state SHALL go to SHIFT.
REQ-017 In SHIFT, each cycle SHALL process one bit, LSB first:
- s = a0^b0^c;
- c' = a0&b0 | c&(a0^b0);
- s SHALL shift into the result register from the MSB side;
- the operand registers SHALL shift right;
- the counter SHALL increment.
REQ-018 When the counter equals WIDTH-1, the same edge SHALL process the last bit and move the state to DONE.
REQ-019 Latency: out_valid SHALL rise exactly WIDTH cycles after the handshake edge.
REQ-020 In DONE:
- out_valid SHALL be 1;
- sum and cout SHALL hold stable until out_valid & out_ready.
REQ-021 On out_valid & out_ready, the state SHALL go to IDLE on the next edge, with no new-operand acceptance in that same cycle.
REQ-022 in_valid in SHIFT or DONE SHALL be ignored, and operands SHALL not be corrupted.
REQ-023 bit_a, bit_b and bit_s SHALL be 0 outside SHIFT, and bit_c SHALL always reflect the carry register.
REQ-024 The counter width SHALL be clog2(WIDTH)+1, and it SHALL never wrap within a transaction.
REQ-025 A mid-transaction out_ready toggle SHALL have no effect until DONE.

Reset
REQ-026 While rst is high at a clock edge:
- state SHALL be IDLE;
- counter, carry, operand and result registers SHALL be 0;
- out_valid SHALL be 0 and busy SHALL be 0.
REQ-027 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-028 rst asserted in SHIFT or DONE SHALL abort the transaction, and no out_valid SHALL be produced for it.
REQ-029 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-030 A shared package bit_serial_adder_pkg SHALL hold the state enum (IDLE, SHIFT, DONE), the default WIDTH constant and the counter-width function.
REQ-031 One sub-module, serial_fa_cell, SHALL implement the combinational full-adder bit (s, c') as two half-adder stages plus an OR.
REQ-032 Top-level RTL SHALL contain only registers, the FSM and serial_fa_cell.

Verification
REQ-033 WIDTH=8, a=0x5A, b=0x33, cin=0 -> sum=0x8D, cout=0, out_valid exactly 8 cycles after the handshake.
REQ-034 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-035 Back-pressure: out_ready held 0 for 5 cycles in DONE -> sum, cout and out_valid stable; in_ready stays 0 until one cycle after out_ready=1.
REQ-036 in_valid pulsed with a=0x11 during SHIFT of 0x5A+0x33 -> the result is still 0x8D, and the pulse is not accepted.
REQ-037 rst asserted after the 3rd SHIFT cycle -> IDLE on the next edge, out_valid never rises, in_ready=1; a following 0x01+0x01 gives 0x02.
REQ-038 Back-to-back transactions with in_valid held high -> exactly one idle cycle between out_valid fall and the next handshake; each result is checked against a reference model for 1000 random operand pairs.
